// File: rtl/fnd_pkg.sv
// Shared types and sizes for the FND digit scanner.
// Position is {page, idx}; digits are packed BCD nibbles.
package fnd_pkg;

  localparam int NUM_DIGITS      = 8;
  localparam int DIGITS_PER_PAGE = 4;
  localparam int POS_W           = 3;
  localparam int BCD_W           = 4;
  localparam int IDX_W           = 2;
  localparam int DIG_W           = NUM_DIGITS * BCD_W;

  typedef struct packed {
    logic             page;
    logic [IDX_W-1:0] idx;
  } pos_t;

  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DIGITS_PER_PAGE - 1);

  function automatic logic [BCD_W-1:0] nibble_at(
    input logic [DIG_W-1:0] digits,
    input logic [POS_W-1:0] pos
  );
    return digits[{pos, 2'b00} +: BCD_W];
  endfunction

endpackage

// File: rtl/fnd_scan_prescaler.sv
// Digit-rate prescaler: counts 0..DIV-1 while enabled.
// Ports: i_clk, i_reset (sync, active-low), i_en, o_tick (wrap cycle).
module fnd_scan_prescaler #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap   = (cnt == CW'(DIV - 1));
  assign o_tick = i_en & wrap;

  // Count is held (not cleared) while disabled so the
  // scan resumes where it stopped.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fnd_digit_scanner.sv
// 8-digit FND scanner: 4 digits per page, frame-aligned paging,
// registered BCD/dot outputs and post-advance anti-ghost blanking.
// Ports: i_clk, i_reset (sync, active-low), i_en, i_page_sel,
//   i_digits[31:0], i_dots[7:0] -> o_digitPosition[2:0], o_bcd[3:0],
//   o_dot, o_blank, o_scan_tick.
module fnd_digit_scanner
  import fnd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_page_sel,
  input  logic [DIG_W-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0] i_dots,
  output logic [POS_W-1:0] o_digitPosition,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_dot,
  output logic             o_blank,
  output logic             o_scan_tick
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int BW  =
    (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BLANK_LOAD =
    (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;

  if (DIV < BLANK_CYCLES + 2) begin : g_bad_div
    $error("fnd_digit_scanner: DIV must be >= BLANK_CYCLES+2");
  end

  logic             adv;
  pos_t             pos_q;
  pos_t             pos_nxt;
  logic [POS_W-1:0] pos_nxt_w;
  logic [BW-1:0]    blank_cnt;
  logic             started;

  fnd_scan_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_en),
    .o_tick  (adv)
  );

  // Page only changes when leaving the last slot of a frame.
  always_comb begin
    pos_nxt      = pos_q;
    pos_nxt.idx  = pos_q.idx + IDX_W'(1);
    if (pos_q.idx == IDX_LAST) begin
      pos_nxt.page = i_page_sel;
    end
    pos_nxt_w = pos_nxt;
  end

  assign o_digitPosition = pos_q;

  // started keeps the display blank from reset until the
  // first advance's blank window has run out.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pos_q       <= '0;
      o_bcd       <= '0;
      o_dot       <= 1'b0;
      o_blank     <= 1'b1;
      o_scan_tick <= 1'b0;
      blank_cnt   <= '0;
      started     <= 1'b0;
    end else if (!i_en) begin
      o_blank     <= 1'b1;
      o_scan_tick <= 1'b0;
    end else if (adv) begin
      pos_q       <= pos_nxt;
      o_bcd       <= nibble_at(i_digits, pos_nxt_w);
      o_dot       <= i_dots[pos_nxt_w];
      o_scan_tick <= 1'b1;
      started     <= 1'b1;
      o_blank     <= (BLANK_CYCLES > 0);
      blank_cnt   <= BLANK_LOAD;
    end else begin
      o_scan_tick <= 1'b0;
      if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - BW'(1);
        o_blank   <= 1'b1;
      end else begin
        o_blank   <= !started;
      end
    end
  end

endmodule
